// File: rtl/alarm_buzzer_ctrl_if.sv
// alarm_buzzer_ctrl_if: clock/alarm time, key pulses and buzzer status between the UI and the buzzer owner
interface alarm_buzzer_ctrl_if;
  logic       tick_1hz;
  logic       tick_beep;
  logic       alarm_on;
  logic [4:0] clk_hr;
  logic [5:0] clk_min;
  logic [5:0] clk_sec;
  logic [4:0] al_hr;
  logic [5:0] al_min;
  logic       snooze;
  logic       stop;
  logic       key_beep;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  modport master (
    output tick_1hz, tick_beep, alarm_on, clk_hr, clk_min, clk_sec, al_hr, al_min, snooze, stop, key_beep,
    input  buzzer, ringing, snoozing
  );
  modport slave (
    input  tick_1hz, tick_beep, alarm_on, clk_hr, clk_min, clk_sec, al_hr, al_min, snooze, stop, key_beep,
    output buzzer, ringing, snoozing
  );
endinterface

// File: rtl/alarm_buzzer_ctrl.sv
// alarm_buzzer_ctrl: shares the buzzer between alarm ring/snooze/timeout sequencing and key-click beeps
module alarm_buzzer_ctrl #(
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_SEC   = 300,
  parameter int BEEP_ON      = 2,
  parameter int BEEP_OFF     = 2,
  parameter int CLICK_LEN    = 1
) (
  input logic clk,
  input logic rst,
  alarm_buzzer_ctrl_if.slave bus
);
  localparam int RW = $clog2(RING_TIMEOUT + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam int PW = $clog2(BEEP_ON + BEEP_OFF + 1);
  localparam int CW = $clog2(CLICK_LEN + 1);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t        state_q, state_d;
  logic          match_d_q, match_d_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [PW-1:0] pat_cnt_q, pat_cnt_d;
  logic [CW-1:0] click_cnt_q, click_cnt_d;
  logic          buzzer_q, buzzer_d;
  logic          match, trig, ring_done, snz_done, enter_ring, in_ring;
  always_comb begin
    match      = bus.alarm_on && bus.clk_hr == bus.al_hr && bus.clk_min == bus.al_min && bus.clk_sec == 6'd0;
    trig       = match && !match_d_q;
    match_d_d  = match;
    in_ring    = state_q == RING;
    ring_done  = bus.tick_1hz && ring_cnt_q == RW'(RING_TIMEOUT - 1);
    snz_done   = bus.tick_1hz && snz_cnt_q == SW'(SNOOZE_SEC - 1);
    state_d    = !bus.alarm_on    ? IDLE :
                 state_q == IDLE  ? (trig ? RING : IDLE) :
                 in_ring          ? (bus.stop ? IDLE : bus.snooze ? SNOOZE : ring_done ? IDLE : RING) :
                                    (bus.stop ? IDLE : snz_done ? RING : SNOOZE);
    enter_ring = state_d == RING && !in_ring;
    // any state change restarts both second counters, so entry always sees zero
    ring_cnt_d = state_d != state_q ? '0 : (in_ring && bus.tick_1hz) ? ring_cnt_q + 1'b1 : ring_cnt_q;
    snz_cnt_d  = state_d != state_q ? '0 : (state_q == SNOOZE && bus.tick_1hz) ? snz_cnt_q + 1'b1 : snz_cnt_q;
    pat_cnt_d  = enter_ring ? '0 :
                 (in_ring && bus.tick_beep) ? (pat_cnt_q == PW'(BEEP_ON + BEEP_OFF - 1) ? '0 : pat_cnt_q + 1'b1) :
                 pat_cnt_q;
    click_cnt_d = enter_ring ? '0 :
                  (bus.key_beep && !in_ring) ? CW'(CLICK_LEN) :
                  (bus.tick_beep && click_cnt_q != '0) ? click_cnt_q - 1'b1 : click_cnt_q;
    // buzzer is computed from next-state values so it changes on the same edge as ringing
    buzzer_d   = state_d == RING ? pat_cnt_d < PW'(BEEP_ON) : click_cnt_d != '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      match_d_q   <= 1'b0;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
      pat_cnt_q   <= '0;
      click_cnt_q <= '0;
      buzzer_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_d_q   <= match_d_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      click_cnt_q <= click_cnt_d;
      buzzer_q    <= buzzer_d;
    end
  end
  assign bus.buzzer   = buzzer_q;
  assign bus.ringing  = state_q == RING;
  assign bus.snoozing = state_q == SNOOZE;
endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// tb_alarm_buzzer_ctrl: randomized scoreboard bench against a countdown-style reference of the buzzer owner
module tb_alarm_buzzer_ctrl;
  localparam int AL_H = 7;
  localparam int AL_M = 30;
  localparam int ALARM_TOD = AL_H * 3600 + AL_M * 60;
  logic clk = 1'b0;
  logic rst = 1'b0;
  alarm_buzzer_ctrl_if bus();
  alarm_buzzer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  int  tod;
  int  mode;
  int  ring_left, snz_left, beep_pos, click_left;
  bit  prev_match;
  function automatic void chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void model_reset();
    mode = 0; ring_left = 0; snz_left = 0; beep_pos = 0; click_left = 0; prev_match = 0;
  endfunction
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("buzzer", bus.buzzer, e[2]);
        chk("ringing", bus.ringing, e[1]);
        chk("snoozing", bus.snoozing, e[0]);
      end
    end
  end
  task automatic cyc(input bit t1, input bit bt, input bit sn, input bit st, input bit kb);
    bit match, trig, entered;
    int old;
    bus.tick_1hz  = t1;
    bus.tick_beep = bt;
    bus.snooze    = sn;
    bus.stop      = st;
    bus.key_beep  = kb;
    bus.clk_hr    = 5'(tod / 3600);
    bus.clk_min   = 6'((tod / 60) % 60);
    bus.clk_sec   = 6'(tod % 60);
    match = bus.alarm_on && (tod / 60) == (ALARM_TOD / 60) && (tod % 60) == 0;
    trig = match && !prev_match;
    prev_match = match;
    old = mode;
    entered = 0;
    if (!bus.alarm_on) mode = 0;
    else if (mode == 0) begin
      if (trig) begin mode = 1; entered = 1; end
    end else if (mode == 1) begin
      if (st) mode = 0;
      else if (sn) begin mode = 2; snz_left = 300; end
      else begin
        if (t1) ring_left--;
        if (ring_left == 0) mode = 0;
        else if (bt) beep_pos++;
      end
    end else begin
      if (st) mode = 0;
      else if (t1) begin
        snz_left--;
        if (snz_left == 0) begin mode = 1; entered = 1; end
      end
    end
    if (entered) begin ring_left = 60; beep_pos = 0; click_left = 0; end
    else if (kb && old != 1) click_left = 1;
    else if (bt && click_left > 0) click_left--;
    exp_q.push_back({mode == 1 ? (beep_pos % 4) < 2 : click_left > 0, mode == 1, mode == 2});
    if (t1) tod = (tod + 1) % 86400;
    @(negedge clk);
  endtask
  task automatic rnd(input int n, input int kbp, input int snp, input int stp);
    for (int i = 0; i < n; i++)
      cyc(i % 4 == 3, $urandom_range(0, 2) == 0, $urandom_range(0, 99) < snp,
          $urandom_range(0, 99) < stp, $urandom_range(0, 99) < kbp);
  endtask
  task automatic arm_and_trigger();
    tod = ALARM_TOD - 1;
    cyc(1, 0, 0, 0, 0);
  endtask
  initial begin
    bus.tick_1hz = 0; bus.tick_beep = 0; bus.snooze = 0; bus.stop = 0; bus.key_beep = 0;
    bus.alarm_on = 0; bus.al_hr = 5'(AL_H); bus.al_min = 6'(AL_M);
    tod = ALARM_TOD - 1;
    bus.clk_hr = 5'(tod / 3600); bus.clk_min = 6'((tod / 60) % 60); bus.clk_sec = 6'(tod % 60);
    model_reset();
    #2 rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_buzzer", bus.buzzer, 1'b0);
    chk("rst_ringing", bus.ringing, 1'b0);
    chk("rst_snoozing", bus.snoozing, 1'b0);
    rst = 0;
    bus.alarm_on = 1;
    arm_and_trigger();
    rnd(270, 10, 0, 0);
    arm_and_trigger();
    rnd(20, 10, 0, 0);
    cyc(0, 0, 1, 0, 1);
    rnd(1300, 5, 0, 0);
    cyc(0, 0, 1, 1, 1);
    rnd(8, 0, 0, 0);
    arm_and_trigger();
    rnd(10, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    rnd(20, 0, 0, 0);
    cyc(0, 0, 1, 1, 1);
    rnd(8, 0, 0, 0);
    tod = ALARM_TOD - 1;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rnd(20, 10, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    rnd(8, 0, 0, 0);
    arm_and_trigger();
    rnd(10, 0, 0, 0);
    bus.alarm_on = 0;
    cyc(0, 0, 0, 0, 0);
    bus.alarm_on = 1;
    rnd(4, 0, 0, 0);
    arm_and_trigger();
    rnd(5, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    rnd(10, 0, 0, 0);
    bus.alarm_on = 0;
    cyc(0, 0, 0, 0, 0);
    bus.alarm_on = 1;
    rnd(4, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      tod = ALARM_TOD - 1 - int'($urandom_range(0, 3));
      rnd(300, 5, 2, 1);
    end
    arm_and_trigger();
    for (int i = 0; i < 10; i++) cyc(0, $urandom_range(0, 1) == 1, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_buzzer", bus.buzzer, 1'b0);
    chk("async_rst_ringing", bus.ringing, 1'b0);
    chk("async_rst_snoozing", bus.snoozing, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) cyc(0, $urandom_range(0, 1) == 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    rnd(6, 0, 0, 0);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
